// File: rtl/canny_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | canny_pkg                                                                  |
// | State encoding, default geometry and parameter checks for the NMS sequencer|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package canny_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_FETCH  = 3'd2,
        S_BEAT   = 3'd3,
        S_WAITWR = 3'd4,
        S_PAUSE  = 3'd5,
        S_DONE   = 3'd6
    } canny_state_e;

    localparam int CANNY_DEF_IMGW = 384;
    localparam int CANNY_DEF_IMGH = 288;
    localparam int CANNY_DEF_PICW = 24;

    // Interior width must split into whole steps; tiny images are handled at run time.
    function automatic bit canny_countstep_ok(input int imgw, input int step);
        if (step < 1) return 1'b0;
        if (imgw < 3) return 1'b1;
        return ((imgw - 2) % step) == 0;
    endfunction

    function automatic bit canny_picw_ok(input int imgw, input int imgh, input int picw);
        return (64'(1) << picw) > (64'(imgw) * 64'(imgh));
    endfunction

endpackage
`default_nettype wire

// File: rtl/canny_beat_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | canny_beat_timer                                                           |
// | Loadable down-counter timing the per-state durations of the sequencer     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module canny_beat_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/canny_nms_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | canny_nms_scheduler                                                        |
// | Raster walk over interior pixels: three-row column fetches, NMS beats and |
// | a ready-handshaked result write per step.                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module canny_nms_scheduler
    import canny_pkg::*;
#(
    parameter int IMGW      = CANNY_DEF_IMGW,
    parameter int IMGH      = CANNY_DEF_IMGH,
    parameter int PICW      = CANNY_DEF_PICW,
    parameter int BEATS     = 4,
    parameter int PAUSE     = 1,
    parameter int COUNTSTEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    output logic            rdEn,
    output logic [PICW-1:0] rdAddrA,
    output logic [PICW-1:0] rdAddrB,
    output logic [PICW-1:0] rdAddrC,
    output logic            nmsEn,
    output logic            wrEn,
    input  logic            wrReady,
    output logic [PICW-1:0] wrAddr,
    output logic [PICW-1:0] pixelCounter,
    output logic            busy,
    output logic            done
);

    if (!canny_countstep_ok(IMGW, COUNTSTEP)) begin : g_bad_countstep
        $error("canny_nms_scheduler: COUNTSTEP must divide IMGW-2");
    end
    if (!canny_picw_ok(IMGW, IMGH, PICW)) begin : g_bad_picw
        $error("canny_nms_scheduler: PICW too narrow for IMGW*IMGH");
    end
    if (BEATS < 1) begin : g_bad_beats
        $error("canny_nms_scheduler: BEATS must be at least 1");
    end

    localparam logic [PICW-1:0] c_one      = PICW'(1);
    localparam logic [PICW-1:0] c_imgw     = PICW'(IMGW);
    localparam logic [PICW-1:0] c_last_col = PICW'(IMGW - 2);
    localparam logic [PICW-1:0] c_last_row = PICW'(IMGH - 2);
    localparam logic [PICW-1:0] c_step     = PICW'(COUNTSTEP);
    localparam logic [PICW-1:0] c_prime_ld = PICW'(COUNTSTEP + 1);
    localparam logic [PICW-1:0] c_fetch_ld = PICW'(COUNTSTEP - 1);
    localparam logic [PICW-1:0] c_beat_ld  = PICW'(BEATS - 1);
    localparam logic [PICW-1:0] c_pause_ld = PICW'((PAUSE > 0) ? PAUSE - 1 : 0);
    localparam bit              c_degenerate = (IMGW < 3) || (IMGH < 3);

    canny_state_e    state_q, state_d;
    logic [PICW-1:0] row_q, row_d;
    logic [PICW-1:0] col_q, col_d;
    logic [PICW-1:0] row_base_q, row_base_d;
    logic [PICW-1:0] fcol_q, fcol_d;
    logic            rd_en_q, rd_en_d;
    logic [PICW-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [PICW-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [PICW-1:0] rd_addr_c_q, rd_addr_c_d;
    logic            nms_en_q, nms_en_d;
    logic            wr_en_q, wr_en_d;
    logic [PICW-1:0] wr_addr_q, wr_addr_d;
    logic [PICW-1:0] pixel_counter_q, pixel_counter_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            tmr_load;
    logic [PICW-1:0] tmr_load_val;
    logic            tmr_en;
    logic [PICW-1:0] tmr_count;
    logic            tmr_zero;
    logic            write_done;
    logic            step_end;
    logic [PICW-1:0] col_adv;
    logic [PICW-1:0] pix_next;
    logic [PICW-1:0] fetch_b;
    logic            more_cols;
    logic            more_rows;

    assign col_adv   = col_q + c_step;
    assign more_cols = (col_adv <= c_last_col);
    assign more_rows = ((row_q + c_one) <= c_last_row);

    canny_beat_timer #(
        .WIDTH(PICW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .en      (tmr_en),
        .count   (tmr_count),
        .zero    (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        row_base_d   = row_base_q;
        fcol_d       = fcol_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rd_en_d      = 1'b0;
        nms_en_d     = 1'b0;
        wr_en_d      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        write_done   = 1'b0;
        step_end     = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (c_degenerate) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = S_PRIME;
                        busy_d       = 1'b1;
                        row_d        = c_one;
                        col_d        = c_one;
                        row_base_d   = c_imgw;
                        fcol_d       = '0;
                        rd_en_d      = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = c_prime_ld;
                    end
                end
            end
            S_PRIME, S_FETCH: begin
                if (tmr_zero) begin
                    state_d      = S_BEAT;
                    nms_en_d     = 1'b1;
                    wr_en_d      = (BEATS == 1);
                    tmr_load     = 1'b1;
                    tmr_load_val = c_beat_ld;
                end else begin
                    tmr_en  = 1'b1;
                    fcol_d  = fcol_q + c_one;
                    rd_en_d = 1'b1;
                end
            end
            S_BEAT: begin
                if (tmr_zero) begin
                    if (wrReady) begin
                        write_done = 1'b1;
                    end else begin
                        state_d = S_WAITWR;
                        wr_en_d = 1'b1;
                    end
                end else begin
                    tmr_en   = 1'b1;
                    nms_en_d = 1'b1;
                    wr_en_d  = (tmr_count == c_one);
                end
            end
            S_WAITWR: begin
                if (wrReady) begin
                    write_done = 1'b1;
                end else begin
                    wr_en_d = 1'b1;
                end
            end
            S_PAUSE: begin
                if (tmr_zero) begin
                    step_end = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (write_done) begin
            if (PAUSE > 0) begin
                state_d      = S_PAUSE;
                tmr_load     = 1'b1;
                tmr_load_val = c_pause_ld;
            end else begin
                step_end = 1'b1;
            end
        end

        // Step-advance decision happens in the same cycle the pause expires.
        if (step_end) begin
            if (more_cols) begin
                state_d      = S_FETCH;
                col_d        = col_adv;
                fcol_d       = col_adv + c_one;
                rd_en_d      = 1'b1;
                tmr_load     = 1'b1;
                tmr_load_val = c_fetch_ld;
            end else if (more_rows) begin
                state_d      = S_PRIME;
                row_d        = row_q + c_one;
                row_base_d   = row_base_q + c_imgw;
                col_d        = c_one;
                fcol_d       = '0;
                rd_en_d      = 1'b1;
                tmr_load     = 1'b1;
                tmr_load_val = c_prime_ld;
            end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
        end

        if (abort) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            rd_en_d  = 1'b0;
            nms_en_d = 1'b0;
            wr_en_d  = 1'b0;
        end

        pix_next        = row_base_d + col_d;
        fetch_b         = row_base_d + fcol_d;
        rd_addr_b_d     = rd_en_d ? fetch_b : '0;
        rd_addr_a_d     = rd_en_d ? (fetch_b - c_imgw) : '0;
        rd_addr_c_d     = rd_en_d ? (fetch_b + c_imgw) : '0;
        wr_addr_d       = wr_en_d ? pix_next : '0;
        pixel_counter_d = busy_d ? pix_next : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            row_q           <= c_one;
            col_q           <= c_one;
            row_base_q      <= c_imgw;
            fcol_q          <= '0;
            rd_en_q         <= 1'b0;
            rd_addr_a_q     <= '0;
            rd_addr_b_q     <= '0;
            rd_addr_c_q     <= '0;
            nms_en_q        <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            pixel_counter_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            col_q           <= col_d;
            row_base_q      <= row_base_d;
            fcol_q          <= fcol_d;
            rd_en_q         <= rd_en_d;
            rd_addr_a_q     <= rd_addr_a_d;
            rd_addr_b_q     <= rd_addr_b_d;
            rd_addr_c_q     <= rd_addr_c_d;
            nms_en_q        <= nms_en_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            pixel_counter_q <= pixel_counter_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign rdEn         = rd_en_q;
    assign rdAddrA      = rd_addr_a_q;
    assign rdAddrB      = rd_addr_b_q;
    assign rdAddrC      = rd_addr_c_q;
    assign nmsEn        = nms_en_q;
    assign wrEn         = wr_en_q;
    assign wrAddr       = wr_addr_q;
    assign pixelCounter = pixel_counter_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_canny_nms_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_canny_nms_scheduler                                                     |
// | Two scheduler configurations checked against a raster-walk model.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_canny_nms_scheduler;

    localparam int PW = 12;

    logic          clk;
    logic          rst_n;
    logic          start_a, start_b;
    logic          abort;
    logic          wr_ready;
    logic          rd_en [2];
    logic [PW-1:0] rd_a  [2];
    logic [PW-1:0] rd_b  [2];
    logic [PW-1:0] rd_c  [2];
    logic          nms   [2];
    logic          wr_en [2];
    logic [PW-1:0] wr_addr [2];
    logic [PW-1:0] pix   [2];
    logic          busy  [2];
    logic          done  [2];

    canny_nms_scheduler #(.IMGW(8), .IMGH(5), .PICW(PW), .BEATS(4), .PAUSE(1), .COUNTSTEP(1)) u_dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .abort(abort),
        .rdEn(rd_en[0]), .rdAddrA(rd_a[0]), .rdAddrB(rd_b[0]), .rdAddrC(rd_c[0]),
        .nmsEn(nms[0]), .wrEn(wr_en[0]), .wrReady(wr_ready), .wrAddr(wr_addr[0]),
        .pixelCounter(pix[0]), .busy(busy[0]), .done(done[0])
    );

    canny_nms_scheduler #(.IMGW(10), .IMGH(4), .PICW(PW), .BEATS(4), .PAUSE(1), .COUNTSTEP(2)) u_dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .abort(abort),
        .rdEn(rd_en[1]), .rdAddrA(rd_a[1]), .rdAddrB(rd_b[1]), .rdAddrC(rd_c[1]),
        .nmsEn(nms[1]), .wrEn(wr_en[1]), .wrReady(wr_ready), .wrAddr(wr_addr[1]),
        .pixelCounter(pix[1]), .busy(busy[1]), .done(done[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int sel = 0;
    bit mon_on = 1'b0;
    int q_ra[$], q_rb[$], q_rc[$], q_wr[$];
    int cyc = 0, rd_cnt, nms_cyc, busy_cyc, done_cnt, nxfer, stall_cnt, first_wr;
    int xfer_cyc[64];
    bit stall_prev;
    int prev_addr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_mon();
        q_ra.delete(); q_rb.delete(); q_rc.delete(); q_wr.delete();
        rd_cnt = 0; nms_cyc = 0; busy_cyc = 0; done_cnt = 0;
        nxfer = 0; stall_cnt = 0; first_wr = -1; stall_prev = 1'b0; prev_addr = 0;
    endtask

    // Every interior pixel in raster order: each row first fetches its whole
    // leading window, then only the new columns each later step needs.
    task automatic build_model(input int w, input int h, input int cs);
        for (int r = 1; r <= h - 2; r++) begin
            for (int c = 0; c <= cs + 1; c++) begin
                q_ra.push_back((r - 1) * w + c); q_rb.push_back(r * w + c); q_rc.push_back((r + 1) * w + c);
            end
            for (int col = 1; col <= w - 2; col += cs) begin
                if (col > 1) begin
                    for (int k = 1; k <= cs; k++) begin
                        q_ra.push_back((r - 1) * w + col + k);
                        q_rb.push_back(r * w + col + k);
                        q_rc.push_back((r + 1) * w + col + k);
                    end
                end
                q_wr.push_back(r * w + col);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_on) begin
                if (rd_en[sel]) begin
                    rd_cnt++;
                    if (q_rb.size() == 0) chk("rd_extra", 1, 0);
                    else begin
                        chk("rdAddrA", int'(rd_a[sel]), q_ra.pop_front());
                        chk("rdAddrB", int'(rd_b[sel]), q_rb.pop_front());
                        chk("rdAddrC", int'(rd_c[sel]), q_rc.pop_front());
                    end
                end
                if ((nms[sel] || wr_en[sel]) && q_wr.size() > 0)
                    chk("pixelCounter", int'(pix[sel]), q_wr[0]);
                if (nms[sel]) nms_cyc++;
                if (wr_en[sel]) begin
                    if (q_wr.size() == 0) chk("wr_extra", 1, 0);
                    else begin
                        chk("wrAddr", int'(wr_addr[sel]), q_wr[0]);
                        if (wr_ready) begin
                            if (nxfer == 0) first_wr = int'(wr_addr[sel]);
                            void'(q_wr.pop_front());
                            if (nxfer < 64) xfer_cyc[nxfer] = cyc;
                            nxfer++;
                        end
                    end
                end
                if (stall_prev) begin
                    stall_cnt++;
                    chk("stall_wrEn", int'(wr_en[sel]), 1);
                    chk("stall_wrAddr", int'(wr_addr[sel]), prev_addr);
                    chk("stall_nmsEn", int'(nms[sel]), 0);
                end
                if (busy[sel]) busy_cyc++;
                if (done[sel]) begin
                    done_cnt++;
                    chk("busy_at_done", int'(busy[sel]), 0);
                end
                stall_prev = wr_en[sel] && !wr_ready;
                prev_addr  = int'(wr_addr[sel]);
            end
        end
    end

    task automatic set_start(input logic v);
        if (sel == 0) start_a = v;
        else start_b = v;
    endtask

    task automatic check_zero(input int s, input string name);
        chk({name, "_strobes"}, int'({rd_en[s], nms[s], wr_en[s], busy[s], done[s]}), 0);
        chk({name, "_addrs"}, int'(rd_a[s] | rd_b[s] | rd_c[s] | wr_addr[s] | pix[s]), 0);
    endtask

    task automatic start_frame(input int s, input int w, input int h, input int cs);
        reset_mon();
        build_model(w, h, cs);
        sel = s;
        mon_on = 1'b1;
        @(posedge clk); #1;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
    endtask

    task automatic wait_pix(input bit on_rd, input int p, input int budget);
        int n = 0;
        while (!(((on_rd && rd_en[sel]) || (!on_rd && nms[sel])) && int'(pix[sel]) == p) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) chk("wait_pix_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget, input bit poke);
        int n = 0;
        while (done[sel] !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (done[sel] !== 1'b1) chk("done_timeout", 0, 1);
        else if (poke) begin
            set_start(1'b1);
            @(posedge clk); #1;
            set_start(1'b0);
            chk("start_in_done", int'(busy[sel]), 0);
            @(posedge clk); #1;
            chk("idle_after_done", int'(busy[sel]), 0);
        end
        @(negedge clk); #1;
    endtask

    task automatic frame_checks(input int x, input int b, input int r, input int nm);
        chk("transfers", nxfer, x);
        chk("busy_cycles", busy_cyc, b);
        chk("read_count", rd_cnt, r);
        chk("nms_cycles", nms_cyc, nm);
        chk("done_pulses", done_cnt, 1);
        chk("writes_left", q_wr.size(), 0);
        chk("reads_left", q_rb.size(), 0);
    endtask

    initial begin
        int d;
        int exp_prime [3][3];
        exp_prime = '{'{8, 16, 24}, '{9, 17, 25}, '{10, 18, 26}};
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; wr_ready = 1'b1;
        reset_mon();
        #12;
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full frame, plus the north/centre/south addresses at the start of row 2.
        start_frame(0, 8, 5, 1);
        chk("model_nwr", q_wr.size(), 18);
        chk("model_first_wr", q_wr[0], 9);
        chk("model_row2_wr", q_wr[6], 17);
        chk("model_last_wr", q_wr[17], 30);
        wait_pix(1'b1, 17, 200);
        for (int i = 0; i < 3; i++) begin
            chk("prime2_A", int'(rd_a[0]), exp_prime[i][0]);
            chk("prime2_B", int'(rd_b[0]), exp_prime[i][1]);
            chk("prime2_C", int'(rd_c[0]), exp_prime[i][2]);
            start_a = (i == 1);
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        wait_done(400, 1'b0);
        frame_checks(18, 114, 24, 72);
        chk("step_spacing", xfer_cyc[1] - xfer_cyc[0], 6);
        chk("row_period", xfer_cyc[6] - xfer_cyc[0], 38);

        // Backpressure on the third write.
        start_frame(0, 8, 5, 1);
        wait_pix(1'b0, 11, 200);
        wr_ready = 1'b0;
        begin
            int n = 0;
            int guard = 0;
            while (n < 6 && guard < 50) begin
                @(posedge clk); #1;
                guard++;
                if (wr_en[0]) n++;
                if (n == 6) wr_ready = 1'b1;
            end
            if (n < 6) chk("stall_timeout", 0, 1);
        end
        wr_ready = 1'b1;
        wait_done(400, 1'b0);
        frame_checks(18, 119, 24, 72);
        chk("stall_cycles", stall_cnt, 5);
        chk("stalled_gap", xfer_cyc[2] - xfer_cyc[1], 11);
        chk("after_stall_gap", xfer_cyc[3] - xfer_cyc[2], 6);

        // Two pixels per step on the wider image.
        start_frame(1, 10, 4, 2);
        chk("model2_nwr", q_wr.size(), 8);
        chk("model2_first_wr", q_wr[0], 11);
        chk("model2_row2_wr", q_wr[4], 21);
        chk("model2_first_fetch", q_rb[4], 14);
        wait_done(400, 1'b0);
        frame_checks(8, 60, 20, 32);
        chk("pair_spacing", xfer_cyc[1] - xfer_cyc[0], 7);

        // Abort during the second step's beats.
        start_frame(0, 8, 5, 1);
        wait_pix(1'b0, 10, 200);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        mon_on = 1'b0;
        check_zero(0, "after_abort");
        d = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            d = d | int'(done[0]) | int'(busy[0]);
        end
        chk("abort_quiet", d, 0);
        abort = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start_a = 1'b0;
        chk("abort_beats_start", int'(busy[0]) + int'(rd_en[0]), 0);
        start_frame(0, 8, 5, 1);
        wait_done(400, 1'b1);
        frame_checks(18, 114, 24, 72);

        // Asynchronous reset in the middle of a fetch cycle.
        start_frame(0, 8, 5, 1);
        wait_pix(1'b1, 10, 200);
        mon_on = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(0, "async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_frame(0, 8, 5, 1);
        wait_done(400, 1'b0);
        frame_checks(18, 114, 24, 72);
        chk("first_wr_after_reset", first_wr, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
